// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// mem_wb_stage_pkg : writeback-select and load-type codes shared with decode
// Revision : 1.0
// ============================================================================
package mem_wb_stage_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// load_align : big-endian sub-word select and extension of a loaded word
// Revision : 1.0
// ============================================================================
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  ld_type,
  output logic [31:0] aligned,
  output logic        misaligned
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Big-endian: the lowest address holds the most significant lane.
  assign half_sel = offset[1] ? rdata[15:0] : rdata[31:16];

  always_comb begin
    byte_sel = rdata[31:24];
    case (offset)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
  end

  always_comb begin
    aligned    = rdata;
    misaligned = 1'b0;
    case (ld_type)
      LD_LH: begin
        aligned    = ext16(half_sel, 1'b1);
        misaligned = offset[0];
      end
      LD_LHU: begin
        aligned    = ext16(half_sel, 1'b0);
        misaligned = offset[0];
      end
      LD_LB:  aligned = ext8(byte_sel, 1'b1);
      LD_LBU: aligned = ext8(byte_sel, 1'b0);
      default: begin
        aligned    = rdata;
        misaligned = (offset != 2'd0);
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// mem_wb_stage : MEM/WB pipeline register, load alignment, writeback select
// Revision : 1.0
// ============================================================================
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter bit ZERO_PROTECT = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             stall,
  input  logic             flush,
  input  logic             m_valid,
  input  logic             m_reg_w,
  input  logic [4:0]       m_dest,
  input  logic [1:0]       m_wb_sel,
  input  logic [2:0]       m_ld_type,
  input  logic [31:0]      m_alu_res,
  input  logic [31:0]      m_mem_rdata,
  input  logic [31:0]      m_link_addr,
  output logic [4:0]       w_reg_addr,
  output logic [31:0]      w_data,
  output logic             reg_w,
  output logic             addr_err,
  output logic [CNT_W-1:0] retire_cnt
);

  logic [31:0] ld_data;
  logic        ld_mis;
  logic        is_load;
  logic        misaligned;
  logic        r0_block;
  logic [31:0] wb_data;
  logic        nxt_reg_w;
  logic        nxt_addr_err;

  load_align u_load_align (
    .rdata      (m_mem_rdata),
    .offset     (m_alu_res[1:0]),
    .ld_type    (m_ld_type),
    .aligned    (ld_data),
    .misaligned (ld_mis)
  );

  assign is_load    = (m_wb_sel == WB_SEL_LOAD);
  assign misaligned = is_load & ld_mis;
  assign r0_block   = ZERO_PROTECT && (m_dest == 5'd0);

  always_comb begin
    wb_data = m_alu_res;
    case (m_wb_sel)
      WB_SEL_LOAD: wb_data = ld_data;
      WB_SEL_LINK: wb_data = m_link_addr;
      default:     wb_data = m_alu_res;
    endcase
  end

  assign nxt_reg_w    = m_valid & m_reg_w & ~misaligned & ~r0_block;
  assign nxt_addr_err = m_valid & misaligned;

  // Stall holds everything except addr_err, which must pulse only once.
  always_ff @(posedge clk) begin
    if (clr) begin
      w_reg_addr <= 5'd0;
      w_data     <= 32'd0;
      reg_w      <= 1'b0;
      addr_err   <= 1'b0;
      retire_cnt <= '0;
    end else if (flush) begin
      w_reg_addr <= 5'd0;
      w_data     <= 32'd0;
      reg_w      <= 1'b0;
      addr_err   <= 1'b0;
    end else if (stall) begin
      addr_err   <= 1'b0;
    end else begin
      w_reg_addr <= m_dest;
      w_data     <= wb_data;
      reg_w      <= nxt_reg_w;
      addr_err   <= nxt_addr_err;
      if (m_valid) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_wb_stage : directed vectors, queue-based scoreboard
// Revision : 1.0
// ============================================================================
module tb_mem_wb_stage;

  typedef struct {
    string       tag;
    logic        rw;
    logic [4:0]  ad;
    logic [31:0] dat;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr, stall, flush, m_valid, m_reg_w;
  logic [4:0]  m_dest;
  logic [1:0]  m_wb_sel;
  logic [2:0]  m_ld_type;
  logic [31:0] m_alu_res, m_mem_rdata, m_link_addr;
  logic [4:0]  w_reg_addr, w_reg_addr2;
  logic [31:0] w_data, w_data2;
  logic        reg_w, addr_err, reg_w2, addr_err2;
  logic [31:0] retire_cnt;
  logic [2:0]  retire_cnt2;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.CNT_W(32), .ZERO_PROTECT(1'b1)) dut (
    .clk(clk), .clr(clr), .stall(stall), .flush(flush), .m_valid(m_valid),
    .m_reg_w(m_reg_w), .m_dest(m_dest), .m_wb_sel(m_wb_sel), .m_ld_type(m_ld_type),
    .m_alu_res(m_alu_res), .m_mem_rdata(m_mem_rdata), .m_link_addr(m_link_addr),
    .w_reg_addr(w_reg_addr), .w_data(w_data), .reg_w(reg_w), .addr_err(addr_err),
    .retire_cnt(retire_cnt)
  );

  // Narrow counter instance exercises the all-ones wrap quickly.
  mem_wb_stage #(.CNT_W(3), .ZERO_PROTECT(1'b1)) dut_w (
    .clk(clk), .clr(clr), .stall(stall), .flush(flush), .m_valid(m_valid),
    .m_reg_w(m_reg_w), .m_dest(m_dest), .m_wb_sel(m_wb_sel), .m_ld_type(m_ld_type),
    .m_alu_res(m_alu_res), .m_mem_rdata(m_mem_rdata), .m_link_addr(m_link_addr),
    .w_reg_addr(w_reg_addr2), .w_data(w_data2), .reg_w(reg_w2), .addr_err(addr_err2),
    .retire_cnt(retire_cnt2)
  );

  task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=0x%08h expected=0x%08h", tag, fld, act, exp);
    end
  endtask

  // Monitor: outputs are registered, so every falling edge presents a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.tag, "reg_w",      {31'd0, reg_w},      {31'd0, e.rw});
        chk(e.tag, "w_reg_addr", {27'd0, w_reg_addr}, {27'd0, e.ad});
        chk(e.tag, "w_data",     w_data,              e.dat);
        chk(e.tag, "addr_err",   {31'd0, addr_err},   {31'd0, e.err});
        chk(e.tag, "retire_cnt", retire_cnt,          e.cnt);
        chk(e.tag, "cnt3",       {29'd0, retire_cnt2}, {29'd0, e.cnt[2:0]});
      end
    end
  end

  task automatic step(input string tag, input logic c, input logic st, input logic fl,
                      input logic v, input logic rw, input logic [4:0] d, input logic [1:0] sel,
                      input logic [2:0] ld, input logic [31:0] alu, input logic [31:0] rd,
                      input logic [31:0] lk, input logic erw, input logic [4:0] ead,
                      input logic [31:0] edat, input logic eerr, input logic [31:0] ecnt);
    exp_t e;
    clr = c; stall = st; flush = fl; m_valid = v; m_reg_w = rw; m_dest = d;
    m_wb_sel = sel; m_ld_type = ld; m_alu_res = alu; m_mem_rdata = rd; m_link_addr = lk;
    @(posedge clk);
    e.tag = tag; e.rw = erw; e.ad = ead; e.dat = edat; e.err = eerr; e.cnt = ecnt;
    q.push_back(e);
    @(negedge clk);
  endtask

  localparam logic [31:0] RD = 32'h8123_F456;

  initial begin
    @(negedge clk);
    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      step("reset", 1, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 2'($urandom),
           3'($urandom), $urandom, $urandom, $urandom, 0, 0, 0, 0, 0);
    step("alu", 0,0,0, 1,1, 5, 2'b00, 3'd0, 32'h7, RD, 0, 1, 5, 32'h7, 0, 1);
    // Byte and half loads
    step("lb0",  0,0,0, 1,1, 8, 2'b01, 3'd3, 32'h100, RD, 0, 1, 8, 32'hFFFF_FF81, 0, 2);
    step("lbu3", 0,0,0, 1,1, 8, 2'b01, 3'd4, 32'h103, RD, 0, 1, 8, 32'h0000_0056, 0, 3);
    step("lb2",  0,0,0, 1,1, 8, 2'b01, 3'd3, 32'h102, RD, 0, 1, 8, 32'hFFFF_FFF4, 0, 4);
    step("lh2",  0,0,0, 1,1, 8, 2'b01, 3'd1, 32'h102, RD, 0, 1, 8, 32'hFFFF_F456, 0, 5);
    step("lhu0", 0,0,0, 1,1, 8, 2'b01, 3'd2, 32'h100, RD, 0, 1, 8, 32'h0000_8123, 0, 6);
    // Misaligned loads
    step("lw_mis", 0,0,0, 1,1, 8, 2'b01, 3'd0, 32'h102, RD, 0, 0, 8, RD, 1, 7);
    step("lh_mis", 0,0,0, 1,1, 8, 2'b01, 3'd1, 32'h101, RD, 0, 0, 8, 32'hFFFF_8123, 1, 8);
    step("idle",   0,0,0, 0,0, 0, 2'b00, 3'd0, 32'h0,   RD, 0, 0, 0, 32'h0, 0, 8);
    step("alu_off",0,0,0, 1,1, 9, 2'b00, 3'd0, 32'h102, RD, 0, 1, 9, 32'h102, 0, 9);
    // r0 target
    step("r0",     0,0,0, 1,1, 0, 2'b00, 3'd0, 32'h55,  RD, 0, 0, 0, 32'h55, 0, 10);
    // Link, then stall
    step("link",   0,0,0, 1,1, 31, 2'b10, 3'd0, 32'h1234, RD, 32'h0040_0008, 1, 31, 32'h0040_0008, 0, 11);
    for (int i = 0; i < 3; i++)
      step("stall", 0,1,0, 1,1, 3, 2'b00, 3'd0, 32'hDEAD, RD, 0, 1, 31, 32'h0040_0008, 0, 11);
    step("mis2",   0,0,0, 1,1, 7, 2'b01, 3'd0, 32'h103, RD, 0, 0, 7, RD, 1, 12);
    step("stall_err", 0,1,0, 1,1, 3, 2'b00, 3'd0, 32'hBEEF, RD, 0, 0, 7, RD, 0, 12);
    step("stall_flush", 0,1,1, 1,1, 3, 2'b00, 3'd0, 32'hBEEF, RD, 0, 0, 0, 32'h0, 0, 12);
    step("sel11",  0,0,0, 1,1, 6, 2'b11, 3'd0, 32'hABC, RD, 32'h999, 1, 6, 32'hABC, 0, 13);
    step("ld7",    0,0,0, 1,1, 6, 2'b01, 3'd7, 32'h100, RD, 0, 1, 6, RD, 0, 14);
    step("flush",  0,0,1, 1,1, 6, 2'b00, 3'd0, 32'h77,  RD, 0, 0, 0, 32'h0, 0, 14);
    // Reset mid-run
    step("clr2",   1,0,0, 1,1, 6, 2'b00, 3'd0, 32'h77,  RD, 0, 0, 0, 32'h0, 0, 0);
    for (int i = 1; i <= 3; i++)
      step("run", 0,0,0, 1,1, 5'(i), 2'b00, 3'd0, 32'(i*16), RD, 0, 1, 5'(i), 32'(i*16), 0, 32'(i));
    step("clr_stall", 1,1,0, 1,1, 4, 2'b00, 3'd0, 32'h99, RD, 0, 0, 0, 32'h0, 0, 0);
    // Nine retirements: the 3-bit counter wraps from 7 to 0
    for (int i = 1; i <= 9; i++)
      step("wrap", 0,0,0, 1,1, 4, 2'b00, 3'd0, 32'(i), RD, 0, 1, 4, 32'(i), 0, 32'(i));

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
